// File: rtl/wb_keyboard.sv
// PS/2 keyboard receiver on a single-beat Wishbone slave port.
// Synchronises the PS/2 pins, deframes 11-bit device-to-host frames,
// buffers good bytes in a FIFO and exposes DATA/STATUS registers with
// sticky overflow and frame-error flags (write-1-to-clear).
module wb_keyboard #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  input  logic        ps2_clk,
  input  logic        ps2_data
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // Synchroniser and edge-detect state
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          fall;

  // Receive FSM state
  rx_state_e     state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push;
  logic          ferr_set;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          not_empty, full;
  logic          pop, do_push, ovf_set;

  // Bus state
  logic          ack_q;
  logic [31:0]   dat_q;
  logic          ovf_q, ferr_q;
  logic          accept;
  logic          clr_ovf, clr_ferr;
  logic [31:0]   cnt_ext;
  logic [31:0]   rd_word;

  logic          unused_bits;

  assign fall = clk_prev_q & ~clk_s2_q;

  // Two-flop synchronisers on both pins plus previous synced clock for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  // Receive FSM and timeout counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tmo_q    <= tmo_d;
    end
  end

  // Frame deframing on each synced falling edge; timeout abandons a stalled frame
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    tmo_d    = tmo_q + TW'(1);
    if (state_q == S_IDLE || fall) begin
      tmo_d = '0;
    end
    if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            bitcnt_d = '0;
            state_d  = S_DATA;
          end
        end
        S_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          parity_d = dat_s2_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          if (dat_s2_q && (^{shift_q, parity_q})) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = S_IDLE;
      ferr_set = 1'b1;
      tmo_d    = '0;
    end
  end

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign accept    = STB & ~ack_q;
  assign pop       = accept & ~WE & ~ADDR[2] & not_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push   = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;
  assign clr_ovf   = accept & WE & ADDR[2] & DAT_I[1];
  assign clr_ferr  = accept & WE & ADDR[2] & DAT_I[2];

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Read-data mux for DATA and STATUS
  always_comb begin
    cnt_ext = 32'(count_q);
    if (ADDR[2]) begin
      rd_word = {20'b0, cnt_ext[3:0], 5'b0, ferr_q, ovf_q, not_empty};
    end else if (not_empty) begin
      rd_word = {23'b0, 1'b1, mem_q[rd_ptr_q]};
    end else begin
      rd_word = '0;
    end
  end

  // Bus acknowledge, registered read data and sticky status flags (set wins)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept && !WE) begin
        dat_q <= rd_word;
      end
      if (ovf_set)       ovf_q <= 1'b1;
      else if (clr_ovf)  ovf_q <= 1'b0;
      if (ferr_set)      ferr_q <= 1'b1;
      else if (clr_ferr) ferr_q <= 1'b0;
    end
  end

  assign ACK   = ack_q;
  assign DAT_O = dat_q;

  assign unused_bits = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:3], DAT_I[0], cnt_ext[31:4]};

endmodule
